// File: rtl/sprite_anim_ctrl.sv
// Sprite-sheet animation controller: turns a one-hot direction request and a
// per-video-frame tick into registered row/column offsets for the sprite ROM.
module sprite_anim_ctrl #(
  parameter int TILE      = 16,
  parameter int FRAMES    = 4,
  parameter int TICK_DIV  = 6,
  parameter int MIRROR_LR = 0,
  parameter int OFF_W     = 9,
  localparam int FW       = $clog2(FRAMES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic [3:0]       dir_in,
  input  logic             freeze,
  output logic [OFF_W-1:0] hoffset,
  output logic [OFF_W-1:0] voffset,
  output logic             hflip,
  output logic             walking,
  output logic [FW-1:0]    frame_idx
);

  localparam int TW = $clog2(TICK_DIV + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WALK = 1'b1
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [1:0]       dir_r, dir_nxt_s;
  logic [TW-1:0]    tcnt_r, tcnt_nxt_s;
  logic [FW-1:0]    frame_r, frame_nxt_s;
  logic             valid_s;
  logic [1:0]       req_dir_s;
  logic [1:0]       row_s;
  logic             flip_s;
  logic [OFF_W-1:0] hoffset_r, voffset_r;
  logic             hflip_r, walking_r;

  // Decode the one-hot request into the dir encoding (down=0, up=1, left=2, right=3)
  always_comb begin
    valid_s   = 1'b1;
    req_dir_s = 2'd0;
    case (dir_in)
      4'b1000: req_dir_s = 2'd1;
      4'b0100: req_dir_s = 2'd0;
      4'b0010: req_dir_s = 2'd2;
      4'b0001: req_dir_s = 2'd3;
      default: valid_s   = 1'b0;
    endcase
  end

  // Next-state logic: leaving WALK and direction changes take priority over ticks
  always_comb begin
    state_nxt_s = state_r;
    dir_nxt_s   = dir_r;
    tcnt_nxt_s  = tcnt_r;
    frame_nxt_s = frame_r;
    if (freeze) begin
      state_nxt_s = state_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (valid_s) begin
            state_nxt_s = WALK;
            dir_nxt_s   = req_dir_s;
            tcnt_nxt_s  = {TW{1'b0}};
            frame_nxt_s = FW'(1);
          end else begin
            tcnt_nxt_s  = {TW{1'b0}};
            frame_nxt_s = {FW{1'b0}};
          end
        end
        WALK: begin
          if (!valid_s) begin
            state_nxt_s = IDLE;
            tcnt_nxt_s  = {TW{1'b0}};
            frame_nxt_s = {FW{1'b0}};
          end else if (req_dir_s != dir_r) begin
            dir_nxt_s   = req_dir_s;
            tcnt_nxt_s  = {TW{1'b0}};
            frame_nxt_s = FW'(1);
          end else if (frame_tick) begin
            if (tcnt_r == TW'(TICK_DIV - 1)) begin
              tcnt_nxt_s  = {TW{1'b0}};
              frame_nxt_s = (frame_r == FW'(FRAMES - 1)) ? {FW{1'b0}} : frame_r + FW'(1);
            end else begin
              tcnt_nxt_s  = tcnt_r + TW'(1);
            end
          end else begin
            tcnt_nxt_s = tcnt_r;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          tcnt_nxt_s  = {TW{1'b0}};
          frame_nxt_s = {FW{1'b0}};
        end
      endcase
    end
  end

  // Row selection; mirror mode folds right-facing onto the left row
  always_comb begin
    row_s  = dir_nxt_s;
    flip_s = 1'b0;
    if ((MIRROR_LR != 0) && (dir_nxt_s == 2'd3)) begin
      row_s  = 2'd2;
      flip_s = 1'b1;
    end else begin
      row_s  = dir_nxt_s;
      flip_s = 1'b0;
    end
  end

  // State and output registers; outputs are built from next-state values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      dir_r     <= 2'd0;
      tcnt_r    <= {TW{1'b0}};
      frame_r   <= {FW{1'b0}};
      hoffset_r <= {OFF_W{1'b0}};
      voffset_r <= {OFF_W{1'b0}};
      hflip_r   <= 1'b0;
      walking_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      dir_r     <= dir_nxt_s;
      tcnt_r    <= tcnt_nxt_s;
      frame_r   <= frame_nxt_s;
      hoffset_r <= OFF_W'(32'(frame_nxt_s) * 32'(TILE));
      voffset_r <= OFF_W'(32'(row_s) * 32'(TILE));
      hflip_r   <= flip_s;
      walking_r <= (state_nxt_s == WALK);
    end
  end

  assign hoffset   = hoffset_r;
  assign voffset   = voffset_r;
  assign hflip     = hflip_r;
  assign walking   = walking_r;
  assign frame_idx = frame_r;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Scoreboard bench: a plain-arithmetic model predicts each cycle's outputs for
// a normal and a mirrored instance; a monitor process pops and compares.
module tb_sprite_anim_ctrl;
  localparam int TD = 3;
  localparam int NF = 4;

  logic       clk = 1'b0;
  logic       rst_n, frame_tick, freeze;
  logic [3:0] dir_in;
  logic [8:0] ho0, vo0, ho1, vo1;
  logic       hf0, wk0, hf1, wk1;
  logic [1:0] fi0, fi1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] v0;
    logic [8:0] v1;
    logic       f1;
    logic       w;
    logic [1:0] fi;
  } exp_t;
  exp_t q[$];

  int m_walk, m_dir, m_ticks;

  sprite_anim_ctrl #(.TILE(16), .FRAMES(NF), .TICK_DIV(TD), .MIRROR_LR(0), .OFF_W(9)) dut0 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .dir_in(dir_in), .freeze(freeze),
    .hoffset(ho0), .voffset(vo0), .hflip(hf0), .walking(wk0), .frame_idx(fi0));

  sprite_anim_ctrl #(.TILE(16), .FRAMES(NF), .TICK_DIV(TD), .MIRROR_LR(1), .OFF_W(9)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .dir_in(dir_in), .freeze(freeze),
    .hoffset(ho1), .voffset(vo1), .hflip(hf1), .walking(wk1), .frame_idx(fi1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int frame;
    frame = m_walk ? (1 + m_ticks / TD) % NF : 0;
    e.h  = 9'(frame * 16);
    e.v0 = 9'(m_dir * 16);
    e.v1 = 9'(((m_dir == 3) ? 2 : m_dir) * 16);
    e.f1 = (m_dir == 3);
    e.w  = (m_walk != 0);
    e.fi = 2'(frame);
    return e;
  endfunction

  task automatic model_step(input logic [3:0] d, input logic t, input logic f);
    int nd;
    if (!f) begin
      nd = -1;
      if (d == 4'b1000) nd = 1;
      if (d == 4'b0100) nd = 0;
      if (d == 4'b0010) nd = 2;
      if (d == 4'b0001) nd = 3;
      if (nd < 0) begin
        m_walk  = 0;
        m_ticks = 0;
      end else if (!m_walk || nd != m_dir) begin
        m_walk  = 1;
        m_dir   = nd;
        m_ticks = 0;
      end else if (t) begin
        m_ticks = (m_ticks + 1) % (TD * NF);
      end
    end
  endtask

  task automatic model_reset();
    m_walk  = 0;
    m_dir   = 0;
    m_ticks = 0;
  endtask

  task automatic step(input logic [3:0] d, input logic t, input logic f);
    @(negedge clk);
    dir_in     = d;
    frame_tick = t;
    freeze     = f;
    model_step(d, t, f);
    q.push_back(model_out());
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " hoffset"}, 32'(ho0), 32'd0);
    chk({tag, " voffset"}, 32'(vo0), 32'd0);
    chk({tag, " hflip"}, 32'(hf0), 32'd0);
    chk({tag, " walking"}, 32'(wk0), 32'd0);
    chk({tag, " frame_idx"}, 32'(fi0), 32'd0);
    chk({tag, " m.voffset"}, 32'(vo1), 32'd0);
    chk({tag, " m.hflip"}, 32'(hf1), 32'd0);
  endtask

  // Monitor: every cycle the DUT presents a new registered output set
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("hoffset", 32'(ho0), 32'(e.h));
        chk("voffset", 32'(vo0), 32'(e.v0));
        chk("hflip", 32'(hf0), 32'd0);
        chk("walking", 32'(wk0), 32'(e.w));
        chk("frame_idx", 32'(fi0), 32'(e.fi));
        chk("m.hoffset", 32'(ho1), 32'(e.h));
        chk("m.voffset", 32'(vo1), 32'(e.v1));
        chk("m.hflip", 32'(hf1), 32'(e.f1));
        chk("m.walking", 32'(wk1), 32'(e.w));
      end
    end
  end

  initial begin
    logic [3:0] cur;
    rst_n = 1'b0; dir_in = 4'b0000; frame_tick = 1'b0; freeze = 1'b0;
    model_reset();
    #23;
    chk_zero("reset");
    @(negedge clk); #2; rst_n = 1'b1;

    // Walk up through a full column cycle
    step(4'b1000, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      step(4'b1000, 1'b1, 1'b0);
      step(4'b1000, 1'b0, 1'b0);
    end
    // Walk right, release, ticks while idle, multi-hot release
    step(4'b0001, 1'b0, 1'b0);
    repeat (4) step(4'b0001, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    repeat (3) step(4'b0000, 1'b1, 1'b0);
    repeat (3) step(4'b0001, 1'b1, 1'b0);
    repeat (2) step(4'b1100, 1'b1, 1'b0);
    // Up to column 3 with 2 ticks, switch left on the wrapping tick
    step(4'b1000, 1'b0, 1'b0);
    repeat (8) step(4'b1000, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    repeat (5) step(4'b0010, 1'b1, 1'b0);
    // Freeze at column 2 with one tick remaining
    for (int i = 0; i < 10; i++) step((i % 2) ? 4'b0100 : 4'b0000, 1'b1, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    // Mirror behaviour right -> left
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0010, 1'b0, 1'b0);

    // Randomized traffic
    cur = 4'b0100;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) != 0) cur = 4'b0001 << $urandom_range(0, 3);
        else cur = 4'($urandom_range(0, 15));
      end
      step(cur, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
    end

    // Asynchronous reset in the middle of a walk
    repeat (5) step(4'b1000, 1'b1, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0; dir_in = 4'b0000; frame_tick = 1'b0; freeze = 1'b0;
    #1;
    chk_zero("async reset");
    q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    #1; rst_n = 1'b1;
    step(4'b0001, 1'b0, 1'b0);
    repeat (6) step(4'b0001, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
